window_gen: RTL and testbench

//  Parametrised sliding-window generator for the streaming pixel pipeline. It replaces the hand-built
//  per-filter row buffers that combine a FIFO with a shift register. It accepts one DATA_WIDTH pixel
//  per en cycle in raster order, tracks its own x/y position, and emits a WIN_ROWS x WIN_COLS window

---
 rtl/window_gen_pkg.sv | 20 ++
 rtl/window_gen_line_ram.sv | 23 ++
 rtl/window_gen.sv | 157 +++++++++++++++
 tb/tb_window_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_gen_pkg.sv
// Shared types for the sliding-window generator.
// Border handling modes and their decoder.
package window_gen_pkg;

   typedef enum logic [1:0] {
      BORDER_VALID     = 2'd0,
      BORDER_ZERO      = 2'd1,
      BORDER_REPLICATE = 2'd2
   } border_e;

   // Encoding 3 is reserved and behaves as VALID.
   function automatic border_e decode_border(input logic [1:0] m);
      case (m)
         2'd1:    return BORDER_ZERO;
         2'd2:    return BORDER_REPLICATE;
         default: return BORDER_VALID;
      endcase
   endfunction

endpackage

// File: rtl/window_gen_line_ram.sv
// One buffered image row: combinational read, write on en.
// A same-address write returns the old word on the read port.
module window_gen_line_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 640,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic [AW-1:0]         addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[addr];

   always_ff @(posedge clk) begin
      if (en) mem[addr] <= wr_data;
   end

endmodule

// File: rtl/window_gen.sv
// Raster-order sliding-window generator with explicit top/left
// border handling; outputs registered one cycle after each pixel.
module window_gen
   import window_gen_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int WIN_ROWS     = 3,
   parameter int WIN_COLS     = 3,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480,
   parameter int LOC_W        = 11
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    en,
   input  logic [DATA_WIDTH-1:0]                   data_in,
   input  logic                                    sof,
   input  logic [1:0]                              border_mode,
   output logic [WIN_ROWS*WIN_COLS*DATA_WIDTH-1:0] win_out,
   output logic                                    win_valid,
   output logic [LOC_W-1:0]                        x_out,
   output logic [LOC_W-1:0]                        y_out,
   output logic                                    frame_done
);

   localparam int AW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
   localparam int CW = $clog2(WIN_COLS);
   localparam int RW = $clog2(WIN_ROWS);
   localparam int NT = WIN_ROWS * WIN_COLS;

   typedef logic [DATA_WIDTH-1:0] tap_t;

   logic [LOC_W-1:0] x_cnt, y_cnt;
   logic [LOC_W-1:0] cur_x, cur_y;
   logic             at_origin, last_px;
   logic             x_last, y_last;
   border_e          mode_q, mode_cur;

   tap_t hist    [WIN_ROWS][WIN_COLS-1];
   tap_t col_new [WIN_ROWS];
   tap_t fw      [WIN_ROWS][WIN_COLS];
   tap_t ram_wr  [WIN_ROWS-1];
   tap_t ram_rd  [WIN_ROWS-1];

   logic [NT*DATA_WIDTH-1:0] win_d;
   logic                     valid_d;

   assign cur_x     = sof ? '0 : x_cnt;
   assign cur_y     = sof ? '0 : y_cnt;
   assign at_origin = (cur_x == '0) && (cur_y == '0);
   assign x_last    = cur_x == LOC_W'(FRAME_WIDTH - 1);
   assign y_last    = cur_y == LOC_W'(FRAME_HEIGHT - 1);
   assign last_px   = x_last && y_last;
   assign mode_cur  = at_origin ? decode_border(border_mode) : mode_q;

   // Row k of the chain holds image row y-1-k.
   for (genvar k = 0; k < WIN_ROWS - 1; k++) begin : g_line
      if (k == 0) begin : g_head
         assign ram_wr[k] = data_in;
      end else begin : g_tail
         assign ram_wr[k] = ram_rd[k-1];
      end

      window_gen_line_ram #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (FRAME_WIDTH),
         .AW         (AW)
      ) u_ram (
         .clk     (clk),
         .en      (en),
         .addr    (cur_x[AW-1:0]),
         .wr_data (ram_wr[k]),
         .rd_data (ram_rd[k])
      );

      assign col_new[WIN_ROWS-2-k] = ram_rd[k];
   end

   assign col_new[WIN_ROWS-1] = data_in;

   for (genvar r = 0; r < WIN_ROWS; r++) begin : g_row
      for (genvar c = 0; c < WIN_COLS; c++) begin : g_col
         if (c < WIN_COLS - 1) begin : g_old
            assign fw[r][c] = hist[r][c];
         end else begin : g_new
            assign fw[r][c] = col_new[r];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         for (int r = 0; r < WIN_ROWS; r++)
            for (int c = 0; c < WIN_COLS - 1; c++)
               hist[r][c] <= fw[r][c+1];
      end
   end

   // Replicate clamps the column first, then the row.
   always_comb begin
      logic [RW-1:0] sr;
      logic [CW-1:0] sc;
      logic          oob_c, oob_r;
      tap_t          tap;
      win_d = '0;
      for (int r = 0; r < WIN_ROWS; r++) begin
         for (int c = 0; c < WIN_COLS; c++) begin
            oob_c = cur_x < LOC_W'(WIN_COLS - 1 - c);
            oob_r = cur_y < LOC_W'(WIN_ROWS - 1 - r);
            sc    = CW'(c);
            sr    = RW'(r);
            if (mode_cur == BORDER_REPLICATE) begin
               if (oob_c) sc = CW'(WIN_COLS - 1) - CW'(cur_x);
               if (oob_r) sr = RW'(WIN_ROWS - 1) - RW'(cur_y);
            end
            tap = fw[sr][sc];
            if (mode_cur == BORDER_ZERO && (oob_c || oob_r))
               tap = '0;
            win_d[(r*WIN_COLS+c)*DATA_WIDTH +: DATA_WIDTH] = tap;
         end
      end
   end

   assign valid_d = (mode_cur != BORDER_VALID) ||
                    ((cur_x >= LOC_W'(WIN_COLS - 1)) &&
                     (cur_y >= LOC_W'(WIN_ROWS - 1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         x_cnt      <= '0;
         y_cnt      <= '0;
         mode_q     <= BORDER_VALID;
         win_out    <= '0;
         win_valid  <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         frame_done <= 1'b0;
      end else begin
         win_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (en) begin
            x_cnt <= x_last ? '0 : cur_x + LOC_W'(1);
            if (x_last)
               y_cnt <= y_last ? '0 : cur_y + LOC_W'(1);
            else
               y_cnt <= cur_y;
            if (at_origin) mode_q <= mode_cur;
            win_out    <= win_d;
            win_valid  <= valid_d;
            x_out      <= cur_x;
            y_out      <= cur_y;
            frame_done <= last_px;
         end
      end
   end

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen on an 8x4 frame with a 3x3 window.
// Expected windows come from a frame-memory model indexed by (x,y).
module tb_window_gen;

   localparam int DW = 8;
   localparam int WR = 3;
   localparam int WC = 3;
   localparam int FW = 8;
   localparam int FH = 4;
   localparam int LW = 4;
   localparam int WB = WR * WC * DW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          en = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          sof = 1'b0;
   logic [1:0]    border_mode = 2'd0;
   logic [WB-1:0] win_out;
   logic          win_valid;
   logic [LW-1:0] x_out, y_out;
   logic          frame_done;

   window_gen #(
      .DATA_WIDTH   (DW),
      .WIN_ROWS     (WR),
      .WIN_COLS     (WC),
      .FRAME_WIDTH  (FW),
      .FRAME_HEIGHT (FH),
      .LOC_W        (LW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .data_in     (data_in),
      .sof         (sof),
      .border_mode (border_mode),
      .win_out     (win_out),
      .win_valid   (win_valid),
      .x_out       (x_out),
      .y_out       (y_out),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WB-1:0] win;
      logic          valid;
      logic          fd;
      logic          care;
      logic [LW-1:0] x;
      logic [LW-1:0] y;
      int            tag;
   } exp_t;

   exp_t          expq[$];
   int            checks = 0;
   int            errors = 0;
   int            valid_cnt = 0;
   int            fd_cnt = 0;
   int            seg = 0;
   logic [WB-1:0] cap [5];

   // Reference model state: frame memory, position, latched mode.
   int mem [FH][FW];
   int mx = 0, my = 0, mmode = 0;

   function automatic logic [WB-1:0] pack9(input int a0, a1, a2, a3,
                                           a4, a5, a6, a7, a8);
      logic [WB-1:0] w;
      int t [9];
      t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      w = '0;
      for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(t[k]);
      return w;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         en          = 1'b0;
         data_in     = DW'($urandom_range(0, 255));
         sof         = 1'($urandom_range(0, 1));
         border_mode = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic send(input bit s, input int bm, input bit rnd);
      exp_t e;
      int d, v, row, col;
      @(negedge clk);
      if (s) begin
         mx = 0;
         my = 0;
      end
      d = rnd ? int'($urandom_range(0, 255)) : my * FW + mx + 1;
      en      = 1'b1;
      sof     = s;
      data_in = DW'(d);
      if (mx == 0 && my == 0) begin
         border_mode = 2'(bm);
         mmode = (bm == 3) ? 0 : bm;
      end else begin
         border_mode = 2'($urandom_range(0, 3));
      end
      mem[my][mx] = d;
      e.x     = LW'(mx);
      e.y     = LW'(my);
      e.fd    = (mx == FW - 1) && (my == FH - 1);
      e.valid = (mmode != 0) || (mx >= WC - 1 && my >= WR - 1);
      e.care  = e.valid;
      e.win   = '0;
      for (int r = 0; r < WR; r++) begin
         for (int c = 0; c < WC; c++) begin
            row = my - (WR - 1 - r);
            col = mx - (WC - 1 - c);
            if (mmode == 2) begin
               if (col < 0) col = 0;
               if (row < 0) row = 0;
            end
            v = (row < 0 || col < 0) ? 0 : mem[row][col];
            e.win[(r*WC+c)*DW +: DW] = DW'(v);
         end
      end
      e.tag = 0;
      if (seg == 1 && mx == 2 && my == 2) e.tag = 1;
      if (seg == 2 && mx == 1 && my == 1) e.tag = 2;
      if (seg == 3 && mx == 0 && my == 1) e.tag = 3;
      if (seg == 3 && mx == 7 && my == 3) e.tag = 4;
      expq.push_back(e);
      mx++;
      if (mx == FW) begin
         mx = 0;
         my++;
         if (my == FH) my = 0;
      end
   endtask

   task automatic frame(input bit s, input int bm, input bit rnd,
                        input int glo, input int ghi, input int n);
      for (int i = 0; i < n; i++) begin
         send(s && i == 0, bm, rnd);
         if (ghi > 0) idle(int'($urandom_range(glo, ghi)));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      en    = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      mx    = 0;
      my    = 0;
      mmode = 0;
   endtask

   task automatic check_counts(input string name, input int ev, input int ef);
      checks++;
      if (valid_cnt !== ev || fd_cnt !== ef) begin
         errors++;
         $display("FAIL %s: valid=%0d frame_done=%0d, required valid=%0d frame_done=%0d",
                  name, valid_cnt, fd_cnt, ev, ef);
      end
      valid_cnt = 0;
      fd_cnt    = 0;
   endtask

   task automatic check_cap(input string name, input int t, input logic [WB-1:0] w);
      checks++;
      if (cap[t] !== w) begin
         errors++;
         $display("FAIL %s: window=%h, required %h", name, cap[t], w);
      end
   endtask

   // Monitor: one expectation per accepted pixel, idle cycles must be quiet.
   initial begin
      exp_t e;
      bit en_s, rst_s;
      forever begin
         @(posedge clk);
         en_s  = en;
         rst_s = reset;
         #1;
         if (rst_s) begin
            checks++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0 || x_out !== '0 ||
                y_out !== '0 || win_out !== '0) begin
               errors++;
               $display("FAIL reset_out: valid=%b fd=%b x=%0d y=%0d win=%h, required all 0",
                        win_valid, frame_done, x_out, y_out, win_out);
            end
         end else if (en_s) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL queue_empty: output after en with no expectation");
            end else begin
               e = expq.pop_front();
               if (win_valid !== e.valid || frame_done !== e.fd ||
                   x_out !== e.x || y_out !== e.y ||
                   (e.care && win_out !== e.win)) begin
                  errors++;
                  $display("FAIL window: got v=%b fd=%b (%0d,%0d) %h, required v=%b fd=%b (%0d,%0d) %h",
                           win_valid, frame_done, x_out, y_out, win_out,
                           e.valid, e.fd, e.x, e.y, e.win);
               end
               if (e.tag != 0) cap[e.tag] = win_out;
               if (win_valid === 1'b1) valid_cnt++;
               if (frame_done === 1'b1) fd_cnt++;
            end
         end else begin
            checks++;
            if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
               errors++;
               $display("FAIL idle_quiet: valid=%b fd=%b, required 0 0",
                        win_valid, frame_done);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 5; k++) cap[k] = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(2);
      @(negedge clk);
      checks++;
      if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_out !== '0 ||
          x_out !== '0 || y_out !== '0) begin
         errors++;
         $display("FAIL reset_idle: v=%b fd=%b x=%0d y=%0d win=%h, required all 0",
                  win_valid, frame_done, x_out, y_out, win_out);
      end
      valid_cnt = 0;
      fd_cnt    = 0;

      seg = 1;
      frame(1'b1, 0, 1'b0, 0, 0, FW * FH);
      idle(3);
      check_counts("valid_frame_count", 12, 1);

      seg = 2;
      frame(1'b1, 1, 1'b0, 0, 0, FW * FH);
      idle(3);
      check_counts("zero_frame_count", 32, 1);

      seg = 3;
      frame(1'b1, 2, 1'b0, 0, 0, FW * FH);
      idle(3);
      check_counts("replicate_frame_count", 32, 1);

      check_cap("valid_first_2_2", 1, pack9(1, 2, 3, 9, 10, 11, 17, 18, 19));
      check_cap("zero_1_1", 2, pack9(0, 0, 0, 0, 1, 2, 0, 9, 10));
      check_cap("repl_0_1", 3, pack9(1, 1, 1, 1, 1, 1, 9, 9, 9));
      check_cap("repl_7_3", 4, pack9(14, 15, 16, 22, 23, 24, 30, 31, 32));

      seg = 4;
      frame(1'b1, 0, 1'b0, 1, 5, FW * FH);
      idle(3);
      check_counts("gap_frame_count", 12, 1);

      seg = 5;
      frame(1'b1, 0, 1'b0, 0, 0, 2 * FW + 5);
      frame(1'b1, 0, 1'b0, 0, 0, FW * FH);
      idle(3);
      check_counts("sof_midframe_count", 15, 1);

      seg = 6;
      frame(1'b1, 0, 1'b0, 0, 0, 3 * FW + 4);
      idle(1);
      do_reset();
      frame(1'b0, 0, 1'b0, 0, 0, FW * FH);
      idle(3);
      check_counts("reset_midframe_count", 20, 1);

      seg = 7;
      for (int f = 0; f < 6; f++)
         frame(f % 2 == 0, int'($urandom_range(0, 3)), 1'b1, 0,
               (f < 2) ? 0 : 3, FW * FH);
      idle(4);
      check_counts("random_frames_done", valid_cnt, 6);

      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
